// File: rtl/cbus_writeback.sv
// C bus write-back stage: fourteen-register file (DMAR, DMDR, R0..R11) written from
// the ALU C bus, with a per-cycle increment port and a data-memory load FSM for DMDR.
//
// Ports:
//   clk, reset        - single clock; asynchronous active-high reset
//   c_sel, c_bus      - destination select (0 none, 1 DMAR, 2 DMDR, 3..14 R0..R11,
//                       15 invalid) and write data
//   inc_sel           - increment select, same encoding as c_sel
//   mem_load          - start a DMDR load from data memory (only seen in IDLE)
//   mem_data/valid    - memory read data and its valid strobe (only seen in REQ)
//   mem_req           - read request, high while a load is outstanding
//   load_busy         - load FSM not idle
//   load_done         - one-cycle pulse after DMDR took memory data
//   load_timeout      - one-cycle pulse after a load was abandoned
//   sel_err           - one-cycle registered pulse for select code 15
//   dmar, dmdr, r0..r11 - registered register-file contents
module cbus_writeback #(
    parameter int unsigned WIDTH   = 19,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       c_sel,
    input  logic [WIDTH-1:0] c_bus,
    input  logic [3:0]       inc_sel,
    input  logic             mem_load,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_valid,
    output logic             mem_req,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_timeout,
    output logic             sel_err,
    output logic [WIDTH-1:0] dmar,
    output logic [WIDTH-1:0] dmdr,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              sel_err_q, sel_err_d;
    logic [WIDTH-1:0]  regs_q [14];
    logic [WIDTH-1:0]  regs_d [14];

    logic              mem_accept;
    logic              cnt_last;
    logic [3:0]        c_idx;
    logic [3:0]        inc_idx;

    assign mem_accept = (state_q == StReq) && mem_valid;
    // This REQ cycle's increment brings the counter to TIMEOUT.
    assign cnt_last   = (cnt_q == CntW'(TIMEOUT - 1));
    assign c_idx      = c_sel - 4'd1;
    assign inc_idx    = inc_sel - 4'd1;

    // ---------------- load FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // ---------------- load FSM: next state ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_load) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                cnt_d = cnt_q + CntW'(1);
                if (mem_valid) begin
                    state_d = StDone;
                end else if (cnt_last) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- load FSM: outputs ----------------
    always_comb begin
        mem_req      = (state_q == StReq);
        load_busy    = (state_q != StIdle);
        load_done    = (state_q == StDone);
        load_timeout = timeout_q;
        sel_err      = sel_err_q;
    end

    // ---------------- register file ----------------
    // Later assignments win: increment < C bus write < memory load data.
    always_comb begin
        for (int i = 0; i < 14; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (inc_sel != 4'd0 && inc_sel != 4'd15) begin
            regs_d[inc_idx] = regs_q[inc_idx] + WIDTH'(1);
        end
        if (c_sel != 4'd0 && c_sel != 4'd15) begin
            regs_d[c_idx] = c_bus;
        end
        if (mem_accept) begin
            regs_d[1] = mem_data;
        end
        sel_err_d = (c_sel == 4'd15) || (inc_sel == 4'd15);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 14; i++) begin
                regs_q[i] <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 14; i++) begin
                regs_q[i] <= regs_d[i];
            end
            sel_err_q <= sel_err_d;
        end
    end

    assign dmar = regs_q[0];
    assign dmdr = regs_q[1];
    assign r0   = regs_q[2];
    assign r1   = regs_q[3];
    assign r2   = regs_q[4];
    assign r3   = regs_q[5];
    assign r4   = regs_q[6];
    assign r5   = regs_q[7];
    assign r6   = regs_q[8];
    assign r7   = regs_q[9];
    assign r8   = regs_q[10];
    assign r9   = regs_q[11];
    assign r10  = regs_q[12];
    assign r11  = regs_q[13];

endmodule
